// File: rtl/remote_rom_server_if.sv
// rtl/remote_rom_server_if.sv - command FIFO, response FIFO and memory port bundle
interface remote_rom_server_if;
    logic        empty;
    logic        rd_en;
    logic [7:0]  dout;
    logic        full;
    logic        wr_en;
    logic [7:0]  din;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport slave (
        input  empty, dout, full, mem_ack, mem_rdata,
        output rd_en, wr_en, din, mem_valid, mem_addr
    );

    modport master (
        output empty, dout, full, mem_ack, mem_rdata,
        input  rd_en, wr_en, din, mem_valid, mem_addr
    );
endinterface

// File: rtl/remote_rom_server.sv
// rtl/remote_rom_server.sv - far-side remote ROM command server (REMOTE_ROM_ECHO_EN: echo address as data)
module remote_rom_server #(
    parameter int ADDR_BYTES = 8,
    parameter int DATA_BYTES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    remote_rom_server_if.slave  bus,
    output logic                busy,
    output logic [15:0]         txn_cnt
);

    typedef enum logic [1:0] {CMD, MEM, RSP} state_t;

    state_t      state;
    logic [3:0]  issued;
    logic [3:0]  got;
    logic        pop_d;
    logic [63:0] addr_buf;
    logic [63:0] addr_next;
    logic [63:0] data_buf;
    logic [2:0]  idx;
    logic        mem_valid_q;
    logic [63:0] mem_addr_q;

    // FIFO strobes are combinational so a pop or push happens in the same cycle as the decision;
    // rd_en is held off during reset so a non-empty FIFO is not drained while the block is cleared
    assign bus.rd_en     = rst_n & (state == CMD) & ~bus.empty & (issued < 4'(ADDR_BYTES));
    assign bus.wr_en     = (state == RSP) & ~bus.full;
    assign bus.din       = (state == RSP) ? 8'(data_buf >> {idx, 3'b000}) : 8'd0;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign busy          = (state != CMD) | (issued != 4'd0);

    // Address buffer with the byte arriving this cycle merged into lane 'got'
    always_comb begin
        addr_next = addr_buf;
        for (int i = 0; i < ADDR_BYTES; i++) begin
            if (got == 4'(i)) begin
                addr_next[8*i +: 8] = bus.dout;
            end
        end
    end

    // Command collection, memory read and response streaming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CMD;
            issued      <= 4'd0;
            got         <= 4'd0;
            pop_d       <= 1'b0;
            addr_buf    <= 64'd0;
            data_buf    <= 64'd0;
            idx         <= 3'd0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 64'd0;
            txn_cnt     <= 16'd0;
        end else begin
            pop_d <= bus.rd_en;
            case (state)
                CMD: begin
                    if (bus.rd_en) begin
                        issued <= issued + 4'd1;
                    end
                    if (pop_d) begin
                        addr_buf <= addr_next;
                        if (got == 4'(ADDR_BYTES - 1)) begin
                            issued <= 4'd0;
                            got    <= 4'd0;
`ifdef REMOTE_ROM_ECHO_EN
                            data_buf <= addr_next;
                            idx      <= 3'd0;
                            state    <= RSP;
`else
                            mem_addr_q  <= addr_next;
                            mem_valid_q <= 1'b1;
                            state       <= MEM;
`endif
                        end else begin
                            got <= got + 4'd1;
                        end
                    end
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        data_buf    <= bus.mem_rdata;
                        mem_valid_q <= 1'b0;
                        idx         <= 3'd0;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (bus.wr_en) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'(DATA_BYTES - 1)) begin
                            txn_cnt <= txn_cnt + 16'd1;
                            state   <= CMD;
                        end
                    end
                end
                default: state <= CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_remote_rom_server.sv
// tb/tb_remote_rom_server.sv - self-checking bench for remote_rom_server
module tb_remote_rom_server;

`ifdef REMOTE_ROM_ECHO_EN
    localparam bit ECHO = 1'b1;
    localparam int NTX  = 2;
`else
    localparam bit ECHO = 1'b0;
    localparam int NTX  = 6;
`endif

    typedef struct {
        logic [63:0] addr;
        logic [63:0] rdata;
        int          starve_at;
        int          full_at;
        int          ack_delay;
        int          reset_at;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] txn_cnt;

    remote_rom_server_if bus();

    remote_rom_server dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .txn_cnt (txn_cnt)
    );

    always #5 clk = ~clk;

    txn_t        tx [NTX];
    logic [7:0]  cmd_q [$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    int          cur = 0;
    int          pops = 0;
    int          pushes = 0;
    int          c8 = -1;
    int          ack_cyc = -1;
    int          exp_txn = 0;
    logic [63:0] addr_reg = 64'd0;
    logic        rd_en_s = 1'b0;

    int          first_pop_cyc [NTX];
    int          last_push_cyc [NTX];
    int          pop_cnt [NTX];
    logic [63:0] seen_addr [NTX];
    logic [7:0]  log_b [NTX][8];
    int          log_n [NTX];
    bit          mv_ever = 1'b0;

    int          rst_left = 3;
    int          starve_left = 0;
    int          full_left = 0;
    int          mem_wait = 0;
    bit          starved [NTX];
    bit          fulled [NTX];
    bit          rst_done [NTX];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] rsp_byte(input int t, input int k);
        logic [63:0] w;
        w = ECHO ? tx[t].addr : tx[t].rdata;
        return w[8*k +: 8];
    endfunction

    // Stimulus: command FIFO, response FIFO backpressure, memory responder, resets
    always @(posedge clk) begin
        #1;
        if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) rst_n = 1'b1;
        end else if (cur < NTX && tx[cur].reset_at == pushes && !rst_done[cur]) begin
            rst_done[cur] = 1'b1;
            rst_n = 1'b0;
            rst_left = 2;
        end

        if (rd_en_s && cmd_q.size() > 0) bus.dout = cmd_q.pop_front();
        else bus.dout = 8'($urandom);

        if (cur < NTX && tx[cur].starve_at == pops && !starved[cur]) begin
            starved[cur] = 1'b1;
            starve_left = 5;
        end
        bus.empty = (cmd_q.size() == 0) || (starve_left > 0);
        if (starve_left > 0) starve_left--;

        if (cur < NTX && tx[cur].full_at == pushes && !fulled[cur]) begin
            fulled[cur] = 1'b1;
            full_left = 4;
        end
        bus.full = (full_left > 0);
        if (full_left > 0) full_left--;

        if (bus.mem_valid && cur < NTX) begin
            bus.mem_ack   = (mem_wait >= tx[cur].ack_delay);
            bus.mem_rdata = bus.mem_ack ? tx[cur].rdata : 64'hBAD0_BAD0_BAD0_BAD0;
            mem_wait++;
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            mem_wait = 0;
        end
    end

    // Transaction-level model and per-cycle compare
    always @(negedge clk) begin
        logic       in_mem;
        logic       in_rsp;
        logic       exp_rd;
        logic [7:0] e_din;
        cyc++;
        rd_en_s = bus.rd_en;
        if (bus.mem_valid) mv_ever = 1'b1;
        if (!rst_n) begin
            if (pops == 8) cur++;
            pops = 0; pushes = 0; c8 = -1; ack_cyc = -1;
            exp_txn = 0; addr_reg = 64'd0;
            chk("rst_rd_en", {63'd0, bus.rd_en}, 64'd0);
            chk("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
            chk("rst_din", {56'd0, bus.din}, 64'd0);
            chk("rst_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
            chk("rst_mem_addr", bus.mem_addr, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_txn_cnt", {48'd0, txn_cnt}, 64'd0);
        end else begin
            in_mem = !ECHO && c8 >= 0 && cyc >= c8 + 2 && ack_cyc < 0;
            in_rsp = ECHO ? (c8 >= 0 && cyc >= c8 + 2) : (ack_cyc >= 0 && cyc > ack_cyc);
            if (!ECHO && c8 >= 0 && cyc == c8 + 2) addr_reg = tx[cur].addr;
            exp_rd = (pops < 8) && !bus.empty;
            e_din  = in_rsp ? rsp_byte(cur, pushes) : 8'd0;

            chk("rd_en", {63'd0, bus.rd_en}, {63'd0, exp_rd});
            chk("wr_en", {63'd0, bus.wr_en}, {63'd0, in_rsp && !bus.full});
            chk("din", {56'd0, bus.din}, {56'd0, e_din});
            chk("mem_valid", {63'd0, bus.mem_valid}, {63'd0, in_mem});
            chk("mem_addr", bus.mem_addr, addr_reg);
            chk("busy", {63'd0, busy}, {63'd0, pops > 0});
            chk("txn_cnt", {48'd0, txn_cnt}, 64'(exp_txn));

            if (cur < NTX) begin
                if (bus.rd_en) pop_cnt[cur]++;
                if (bus.mem_valid) seen_addr[cur] = bus.mem_addr;
                if (bus.wr_en && log_n[cur] < 8) begin
                    log_b[cur][log_n[cur]] = bus.din;
                    log_n[cur]++;
                end
            end

            if (exp_rd) begin
                if (pops == 0) first_pop_cyc[cur] = cyc;
                pops++;
                if (pops == 8) c8 = cyc;
            end
            if (in_mem && bus.mem_ack) ack_cyc = cyc;
            if (in_rsp && !bus.full) begin
                pushes++;
                if (pushes == 8) begin
                    last_push_cyc[cur] = cyc;
                    exp_txn++;
                    cur++;
                    pops = 0; pushes = 0; c8 = -1; ack_cyc = -1;
                end
            end
        end
    end

    initial begin
        logic [7:0] t0_exp [8];
`ifdef REMOTE_ROM_ECHO_EN
        tx[0] = '{64'h0123_4567_89AB_CDEF, 64'h0, -1, -1, 0, -1};
        tx[1] = '{64'h8877_6655_4433_2211, 64'h0, -1, 2, 0, -1};
`else
        tx[0] = '{64'hEFCD_AB89_6745_2301, 64'h1122_3344_5566_7788, -1, -1, 0, -1};
        tx[1] = '{64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF, 3, -1, 0, -1};
        tx[2] = '{64'h1000_0000_0000_0001, 64'h0F1E_2D3C_4B5A_6978, -1, 2, 0, -1};
        tx[3] = '{64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, -1, -1, 10, -1};
        tx[4] = '{64'h5555_AAAA_5555_AAAA, 64'hDEAD_BEEF_DEAD_BEEF, -1, -1, 0, 3};
        tx[5] = '{64'hAABB_CCDD_EEFF_0011, 64'hCAFE_F00D_1234_5678, -1, -1, 0, -1};
`endif
        for (int t = 0; t < NTX; t++) begin
            pop_cnt[t] = 0; log_n[t] = 0; seen_addr[t] = 64'd0;
            first_pop_cyc[t] = 0; last_push_cyc[t] = 0;
            starved[t] = 1'b0; fulled[t] = 1'b0; rst_done[t] = 1'b0;
            for (int k = 0; k < 8; k++) cmd_q.push_back(tx[t].addr[8*k +: 8]);
        end
        bus.empty = 1'b1; bus.full = 1'b0; bus.dout = 8'd0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 64'd0;

        while (cur < NTX && cyc < 3000) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("all_txns_done", 64'(cur), 64'(NTX));

`ifdef REMOTE_ROM_ECHO_EN
        t0_exp = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        for (int k = 0; k < 8; k++) chk("echo_din_seq", {56'd0, log_b[0][k]}, {56'd0, t0_exp[k]});
        chk("echo_mem_valid_never", {63'd0, mv_ever}, 64'd0);
        chk("echo_bp_bytes", 64'(log_n[1]), 64'd8);
        chk("echo_bp_byte2", {56'd0, log_b[1][2]}, 64'h33);
        chk("final_txn_cnt", {48'd0, txn_cnt}, 64'd2);
`else
        t0_exp = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        chk("basic_mem_addr", seen_addr[0], 64'hEFCD_AB89_6745_2301);
        for (int k = 0; k < 8; k++) chk("basic_din_seq", {56'd0, log_b[0][k]}, {56'd0, t0_exp[k]});
        chk("basic_cycles", 64'(last_push_cyc[0] - first_pop_cyc[0] + 1), 64'd18);
        chk("starve_pops", 64'(pop_cnt[1]), 64'd8);
        chk("starve_mem_addr", seen_addr[1], 64'h0011_2233_4455_6677);
        chk("bp_bytes", 64'(log_n[2]), 64'd8);
        chk("bp_byte2", {56'd0, log_b[2][2]}, 64'h5A);
        chk("bp_byte3", {56'd0, log_b[2][3]}, 64'h4B);
        chk("slow_mem_addr", seen_addr[3], 64'hFEDC_BA98_7654_3210);
        chk("reset_partial_bytes", 64'(log_n[4]), 64'd3);
        chk("post_reset_addr", seen_addr[5], 64'hAABB_CCDD_EEFF_0011);
        chk("post_reset_byte0", {56'd0, log_b[5][0]}, 64'h78);
        chk("post_reset_byte7", {56'd0, log_b[5][7]}, 64'hCA);
        chk("final_txn_cnt", {48'd0, txn_cnt}, 64'd1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/remote_rom_server.md
# remote_rom_server

Far-side command server for the remote ROM link. It pops 8 little-endian address bytes from the read side of the command FIFO and performs one 64-bit read on a local memory port. It then pushes the 8 data bytes, low byte first, into the write side of the response FIFO. It runs entirely in the link clock domain, between the two dual-clock `ip_fifo` instances that connect it to `remote_rom`.

## Interface
- `ADDR_BYTES`, 8: command length in bytes. Fixed at 8 for the 64-bit address.
- `DATA_BYTES`, 8: response length in bytes. Fixed at 8 for 64-bit data.
- `clk  in  1`: link clock. All state is on the rising edge.
- `rst_n  in  1`: reset. Asynchronous and active-low.
- `empty  in  1`: command FIFO empty.
- `rd_en  out  1`: command FIFO pop.
- `dout  in  8`: command FIFO data. Valid in the cycle after the pop.
- `full  in  1`: response FIFO full.
- `wr_en  out  1`: response FIFO push.
- `din  out  8`: response FIFO data.
- `mem_valid  out  1`: memory read request.
- `mem_addr  out  64`: memory read address.
- `mem_ack  in  1`: memory read done. `mem_rdata` is valid in the same cycle.
- `mem_rdata  in  64`: memory read data.
- `busy  out  1`: high whenever the state is not CMD or any command byte is pending.
- `txn_cnt  out  16`: number of completed transactions.

## Operation
- States: CMD, MEM, RSP. Reset state is CMD.
- CMD state:
  - `rd_en = ~empty & (issued < 8)`. This is combinational.
  - `issued` is a 4-bit counter of pops.
  - A registered `pop_d` flag marks the next cycle's `dout` as valid.
  - On `pop_d`, `dout` is written into `addr_buf[got]` and `got` increments. Byte `got` lands in bits `[8*got+7:8*got]`.
  - When the 8th byte is captured: `mem_addr <= addr_buf`, `mem_valid <= 1`, go to MEM.
  - Both counters clear on leaving CMD.
- MEM state:
  - `mem_valid` is held high until `mem_ack` is sampled high.
  - On ack: `data_buf <= mem_rdata`, `mem_valid <= 0`, `idx <= 0`, go to RSP.
  - `mem_addr` is passed through unmodified, with no alignment.
- RSP state:
  - `wr_en = ~full`. This is combinational.
  - `din = data_buf[8*idx+7:8*idx]`.
  - Each cycle with `wr_en` high, `idx` increments.
  - On the push with `idx == 7`: go to CMD and increment `txn_cnt`.
- `txn_cnt` wraps from 0xFFFF to 0. There is no saturation.
- Outside RSP, `wr_en = 0` and `din = 0`. Outside CMD, `rd_en = 0`.

## Timing
- Reset values: `rd_en = 0`, `wr_en = 0`, `din = 0`, `mem_valid = 0`, `mem_addr = 0`, `busy = 0`, `txn_cnt = 0`. All buffers and counters are 0.
- With `empty` low throughout, 8 pops occur on 8 consecutive cycles. The 8th byte is captured one cycle after the 8th pop, and `mem_valid` rises on that same edge.
- `mem_ack` may arrive in the first cycle `mem_valid` is high.
- MEM-to-RSP transition takes 1 cycle. With `full` low, the 8 bytes are pushed on 8 consecutive cycles.
- Minimum transaction, with zero-wait ack: 8 pop cycles, 1 capture cycle, 1 MEM cycle, 8 RSP cycles, 18 cycles total.
- `empty` going high mid-command: pops stall, counters hold, no timeout. An in-flight `pop_d` still captures its byte.
- `full` going high mid-response: the push stalls and `idx` and `din` hold. No byte is lost or duplicated.
- The next command is not popped until RSP completes. There is no overlap.
- Reset mid-operation clears everything to reset values and discards the partial address or data. FIFO contents are not flushed.

## Configuration
- `REMOTE_ROM_ECHO_EN` defined:
  - After the 8th byte, the block goes CMD to RSP directly, with `data_buf <= addr_buf`.
  - `mem_valid` is constant 0 and `mem_ack` is ignored.
  - Every response echoes its address, for link bring-up without memory.
- `REMOTE_ROM_ECHO_EN` undefined: normal memory read as described above.

## Test plan
- Basic read: bytes 01,23,45,67,89,AB,CD,EF pushed, `mem_ack` on the first MEM cycle with `mem_rdata = 64'h1122_3344_5566_7788`.
  - Required: `mem_addr = 64'hEFCD_AB89_6745_2301`.
  - Required: `din` sequence 88,77,66,55,44,33,22,11, then `txn_cnt = 1`.
- Starved command: `empty` high for 5 cycles after byte 3.
  - Required: exactly 8 pops total and `mem_addr` still correct.
  - Required: `rd_en` never high while `empty` is high.
- Backpressure: `full` high for 4 cycles after byte 2 of the response.
  - Required: `din` holds byte 2 and no byte is repeated in the captured stream.
- Slow memory: `mem_ack` delayed 10 cycles.
  - Required: `mem_valid` and `mem_addr` stable throughout, and no pop or push in MEM.
- Reset mid-response: `rst_n` low after 3 data bytes.
  - Required: all outputs return to reset values.
  - Required: the next full command (AABB_CCDD_EEFF_0011) completes correctly.
- Echo build, with `REMOTE_ROM_ECHO_EN` defined: address `64'h0123_4567_89AB_CDEF` in.
  - Required: `din` sequence EF,CD,AB,89,67,45,23,01, with `mem_valid` never high.
